serial_add_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_ctrl_if.sv | 28 ++
 rtl/full_adder_slice.sv | 44 ++++
 rtl/serial_add_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle between caller and serial adder
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder_slice.sv
// rtl/full_adder_slice.sv - one-bit full adder built from two half adders

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module full_adder_slice (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .c (c1)
  );

  // Only one of the two half adders can generate a carry at a time.
  assign co = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract engine sequencing one full-adder slice
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic             slice_s;
  logic             slice_c;

  full_adder_slice u_slice (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_c)
  );

  assign last_bit = (cnt == LAST_CNT);

  // Next-state logic: start is only honoured when not already running.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_n = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Operand load on accept, then one LSB-first bit per RUN cycle into the result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= bus.a;
      op_b  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub ? 1'b1 : bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      res   <= {slice_s, res[WIDTH-1:1]};
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= slice_c;
      // Hold on the final bit so the counter never wraps inside an operation.
      if (!last_bit) cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = res;
  assign bus.cout = carry;

endmodule
